// File: rtl/slot_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : slot_game_ctrl
// Purpose  : Slot-machine game sequencer. Keeps the balance, runs the reel
//            spin/settle/result timing, applies payouts and drives the 7-seg
//            select.
// Revision : 1.0  initial release
// ============================================================================
module slot_game_ctrl #(
  parameter int BAL_W         = 10,
  parameter int INIT_BAL      = 10,
  parameter int MAX_BAL       = 999,
  parameter int BET           = 2,
  parameter int COIN_VAL      = 5,
  parameter int SPIN_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int RESULT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spin_req,
  input  logic             coin_in,
  input  logic [3:0]       score,
  output logic             spin,
  output logic             show_balance,
  output logic [BAL_W-1:0] balance,
  output logic [3:0]       last_win,
  output logic [2:0]       state
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_SPIN   = 3'd1;
  localparam logic [2:0] c_SETTLE = 3'd2;
  localparam logic [2:0] c_RESULT = 3'd3;
  localparam logic [2:0] c_BROKE  = 3'd4;

  localparam int c_MAX_A   = (SPIN_CYCLES > SETTLE_CYCLES) ? SPIN_CYCLES : SETTLE_CYCLES;
  localparam int c_MAX_CYC = (c_MAX_A > RESULT_CYCLES) ? c_MAX_A : RESULT_CYCLES;
  localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
  localparam int c_SUM_W   = BAL_W + 5;

  localparam logic [c_CNT_W-1:0] c_SPIN_LAST   = c_CNT_W'(SPIN_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_RESULT_LAST = c_CNT_W'(RESULT_CYCLES - 1);

  localparam logic [c_SUM_W-1:0] c_BET      = c_SUM_W'(BET);
  localparam logic [c_SUM_W-1:0] c_COIN     = c_SUM_W'(COIN_VAL);
  localparam logic [c_SUM_W-1:0] c_MAX      = c_SUM_W'(MAX_BAL);
  localparam logic [BAL_W-1:0]   c_MAX_BAL  = BAL_W'(MAX_BAL);
  localparam logic [BAL_W-1:0]   c_INIT_BAL = BAL_W'(INIT_BAL);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [BAL_W-1:0]   r_balance;
  logic [BAL_W-1:0]   w_balance_nxt;
  logic [3:0]         r_last_win;
  logic [3:0]         w_last_win_nxt;
  logic               r_spin;
  logic               w_spin_nxt;
  logic               r_show;
  logic               w_show_nxt;
  logic               w_bal_ok;
  logic               w_accept;
  logic               w_pay;
  logic [c_SUM_W-1:0] w_sum;

  assign w_bal_ok = (c_SUM_W'(r_balance) >= c_BET);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; spin_req only matters in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (spin_req) begin
          w_state_nxt = w_bal_ok ? c_SPIN : c_BROKE;
        end
      end
      c_SPIN: begin
        if (r_cnt == c_SPIN_LAST) begin
          w_state_nxt = c_SETTLE;
        end
      end
      c_SETTLE: begin
        if (r_cnt == c_SETTLE_LAST) begin
          w_state_nxt = c_RESULT;
        end
      end
      c_RESULT: begin
        if (r_cnt == c_RESULT_LAST) begin
          w_state_nxt = c_IDLE;
        end
      end
      c_BROKE: begin
        if (w_bal_ok) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output / datapath next values; debit, coin and payout combine in one sum
  always_comb begin
    w_accept = (r_state == c_IDLE) && spin_req && w_bal_ok;
    w_pay    = (r_state == c_SETTLE) && (r_cnt == c_SETTLE_LAST);

    if ((w_state_nxt != r_state) || (r_state == c_IDLE) || (r_state == c_BROKE)) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + c_CNT_W'(1);
    end

    w_sum = c_SUM_W'(r_balance);
    if (w_accept) begin
      w_sum = w_sum - c_BET;
    end
    if (coin_in) begin
      w_sum = w_sum + c_COIN;
    end
    if (w_pay) begin
      w_sum = w_sum + (c_SUM_W'(score) * c_BET);
    end

    if (w_sum > c_MAX) begin
      w_balance_nxt = c_MAX_BAL;
    end else begin
      w_balance_nxt = w_sum[BAL_W-1:0];
    end

    w_last_win_nxt = w_pay ? score : r_last_win;
    w_spin_nxt     = (w_state_nxt == c_SPIN);
    w_show_nxt     = (w_state_nxt == c_IDLE) || (w_state_nxt == c_BROKE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_balance  <= c_INIT_BAL;
      r_last_win <= 4'd0;
      r_spin     <= 1'b0;
      r_show     <= 1'b1;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_balance  <= w_balance_nxt;
      r_last_win <= w_last_win_nxt;
      r_spin     <= w_spin_nxt;
      r_show     <= w_show_nxt;
    end
  end

  assign spin         = r_spin;
  assign show_balance = r_show;
  assign balance      = r_balance;
  assign last_win     = r_last_win;
  assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_slot_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_slot_game_ctrl
// Purpose  : Self-checking bench for slot_game_ctrl: directed scenarios plus
//            random stimulus compared every cycle against a round-timeline model.
// Revision : 1.0  initial release
// ============================================================================
module tb_slot_game_ctrl;

  localparam int c_BAL_W  = 10;
  localparam int c_INIT   = 10;
  localparam int c_MAX    = 999;
  localparam int c_BET    = 2;
  localparam int c_COIN   = 5;
  localparam int c_S      = 8;
  localparam int c_T      = 2;
  localparam int c_R      = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               spin_req = 1'b0;
  logic               coin_in = 1'b0;
  logic [3:0]         score = 4'd0;
  logic               spin;
  logic               show_balance;
  logic [c_BAL_W-1:0] balance;
  logic [3:0]         last_win;
  logic [2:0]         state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a round is described by edges elapsed since acceptance
  int m_bal;
  int m_lw;
  bit m_round;
  bit m_broke;
  int m_e;

  slot_game_ctrl #(
    .BAL_W(c_BAL_W), .INIT_BAL(c_INIT), .MAX_BAL(c_MAX), .BET(c_BET),
    .COIN_VAL(c_COIN), .SPIN_CYCLES(c_S), .SETTLE_CYCLES(c_T), .RESULT_CYCLES(c_R)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spin_req(spin_req), .coin_in(coin_in),
    .score(score), .spin(spin), .show_balance(show_balance),
    .balance(balance), .last_win(last_win), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bal = c_INIT; m_lw = 0; m_round = 0; m_broke = 0; m_e = 0;
  endtask

  task automatic model_edge(input bit sr, input bit cn, input int sc);
    int nb;
    nb = m_bal;
    if (m_round) begin
      if (m_e == c_S + c_T - 1) begin
        nb += sc * c_BET;
        m_lw = sc;
      end
      m_e++;
      if (m_e == c_S + c_T + c_R) m_round = 0;
    end else if (m_broke) begin
      if (m_bal >= c_BET) m_broke = 0;
    end else if (sr) begin
      if (m_bal >= c_BET) begin
        nb -= c_BET; m_round = 1; m_e = 0;
      end else begin
        m_broke = 1;
      end
    end
    if (cn) nb += c_COIN;
    if (nb > c_MAX) nb = c_MAX;
    m_bal = nb;
  endtask

  function automatic int exp_state();
    if (m_round) begin
      if (m_e < c_S) return 1;
      if (m_e < c_S + c_T) return 2;
      return 3;
    end
    return m_broke ? 4 : 0;
  endfunction

  task automatic compare_all();
    int es;
    es = exp_state();
    check("state", int'(state), es);
    check("spin", int'(spin), (es == 1) ? 1 : 0);
    check("show_balance", int'(show_balance), (es == 0 || es == 4) ? 1 : 0);
    check("balance", int'(balance), m_bal);
    check("last_win", int'(last_win), m_lw);
  endtask

  // Called at a negedge: drive, take one posedge, sample at the next negedge
  task automatic cycle(input bit sr, input bit cn, input int sc);
    spin_req = sr; coin_in = cn; score = 4'(sc);
    @(posedge clk);
    model_edge(sr, cn, sc);
    @(negedge clk);
    spin_req = 1'b0; coin_in = 1'b0;
    compare_all();
  endtask

  task automatic run(input int n, input bit sr, input bit cn, input int sc);
    for (int i = 0; i < n; i++) cycle(sr, cn, sc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; spin_req = 1'b0; coin_in = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);

    // Basic round with score 3
    do_reset();
    check("rst_bal", int'(balance), 10);
    check("rst_show", int'(show_balance), 1);
    cycle(1, 0, 3);
    check("t1_spin", int'(spin), 1);
    check("t1_debit", int'(balance), 8);
    run(10, 0, 0, 3);
    check("t1_payout", int'(balance), 14);
    check("t1_lastwin", int'(last_win), 3);
    check("t1_result_show", int'(show_balance), 0);
    run(3, 0, 0, 3);
    check("t1_result_end_show", int'(show_balance), 0);
    cycle(0, 0, 3);
    check("t1_idle_show", int'(show_balance), 1);
    check("t1_idle_state", int'(state), 0);

    // Drain to zero, then BROKE and recovery by coin
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, 0);
      run(c_S + c_T + c_R, 0, 0, 0);
    end
    check("t2_zero", int'(balance), 0);
    cycle(1, 0, 0);
    check("t2_broke", int'(state), 4);
    check("t2_broke_spin", int'(spin), 0);
    cycle(0, 1, 0);
    check("t3_coin", int'(balance), 5);
    check("t3_still_broke", int'(state), 4);
    cycle(0, 0, 0);
    check("t3_idle", int'(state), 0);
    cycle(1, 0, 0);
    check("t3_debit", int'(balance), 3);
    run(c_S + c_T + c_R, 0, 0, 0);

    // Coin and spin on the same edge
    do_reset();
    cycle(1, 1, 0);
    check("t4_bal", int'(balance), 13);
    check("t4_state", int'(state), 1);
    run(c_S + c_T + c_R, 0, 0, 0);

    // Saturation at the ceiling
    do_reset();
    run(196, 0, 1, 0);
    check("t5_990", int'(balance), 990);
    cycle(1, 0, 15);
    run(c_S + c_T + c_R, 0, 0, 15);
    check("t5_sat", int'(balance), 999);
    cycle(0, 1, 0);
    check("t5_coin_sat", int'(balance), 999);

    // spin_req during a round is ignored
    do_reset();
    cycle(1, 0, 5);
    run(c_S + c_T + c_R, 1, 0, 5);
    check("t6_one_debit", int'(balance), 18);
    check("t6_idle", int'(state), 0);

    // Asynchronous reset in the middle of SPIN
    cycle(1, 0, 0);
    run(3, 0, 0, 0);
    check("t6_spinning", int'(spin), 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_spin", int'(spin), 0);
    check("t6_async_bal", int'(balance), 10);
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(3) == 0), ($urandom_range(9) == 0), int'($urandom_range(15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
